// File: rtl/tff_toggle_decoder.sv
// rtl/tff_toggle_decoder.sv - toggle-flag event receiver: sync, edge detect, pending queue, handshake
//
// Purpose:
//   Recovers events from a toggle-encoded level line driven by a remote T
//   flip-flop. Each transition on tog_in becomes one evt_pulse, the event is
//   queued in a saturating pending counter and released one at a time over a
//   valid/ready handshake.
//
// Optional feature (macro TFF_DEC_STAT_EN):
//   Adds the evt_total port, a wrapping count of every detected event,
//   dropped events included.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   tog_in     in   toggle-encoded event line, asynchronous to clk
//   evt_pulse  out  one-cycle pulse per detected tog_in transition
//   evt_valid  out  at least one event pending
//   evt_ready  in   consumer accepts one event when evt_valid=1
//   pend_cnt   out  number of pending events (saturates at 2^PEND_W-1)
//   ovf        out  sticky: an event was dropped while the counter was full
//   ovf_clr    in   synchronous clear of ovf (a same-cycle overflow wins)
//   evt_total  out  wrapping total event count (TFF_DEC_STAT_EN only)

module tff_toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int TOT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  output logic              evt_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf,
`ifdef TFF_DEC_STAT_EN
  input  logic              ovf_clr,
  output logic [TOT_W-1:0]  evt_total
`else
  input  logic              ovf_clr
`endif
);

  localparam logic [PEND_W-1:0] PMAX     = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FULL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync_last;
  logic                   edge_ref;
  logic                   init_q;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // The synchroniser flops come out of reset at 0, not at the line's real
  // level. fill_q marks when the last stage holds a genuine post-reset sample;
  // until then the edge reference just follows the last stage, so a line
  // sitting at 1 through reset never produces a phantom event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      fill_q    <= '0;
      edge_ref  <= 1'b0;
      init_q    <= 1'b1;
      evt_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      edge_ref <= sync_last;
      if (init_q) begin
        evt_pulse <= 1'b0;
        if (fill_q[SYNC_STAGES-1]) begin
          init_q <= 1'b0;
        end
      end else begin
        evt_pulse <= sync_last ^ edge_ref;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending counter FSM
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [PEND_W-1:0] cnt_d;
  logic              ovf_set;
  logic              inc;
  logic              dec;

  assign inc = evt_pulse;
  assign dec = evt_valid & evt_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = pend_cnt;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (inc) begin
          cnt_d   = pend_cnt + PEND_ONE;
          state_d = (cnt_d == PMAX) ? FULL : PEND;
        end
      end
      PEND: begin
        if (inc && !dec) begin
          cnt_d = pend_cnt + PEND_ONE;
          if (cnt_d == PMAX) begin
            state_d = FULL;
          end
        end else if (dec && !inc) begin
          cnt_d = pend_cnt - PEND_ONE;
          if (cnt_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      FULL: begin
        if (dec && !inc) begin
          cnt_d   = pend_cnt - PEND_ONE;
          state_d = (cnt_d == '0) ? IDLE : PEND;
        end else if (inc && !dec) begin
          // No room: the event is lost and recorded in ovf.
          ovf_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // evt_valid is registered from the next state so that the consumer never
  // sees a combinational path from evt_ready back to evt_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_cnt  <= '0;
      evt_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_cnt  <= cnt_d;
      evt_valid <= (state_d != IDLE);
      ovf       <= ovf_set | (ovf & ~ovf_clr);
    end
  end

`ifdef TFF_DEC_STAT_EN
  // ---------------------------------------------------------------------------
  // Total-event statistic: counts every pulse, including dropped ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_total <= '0;
    end else if (evt_pulse) begin
      evt_total <= evt_total + TOT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// tb/tb_tff_toggle_decoder.sv - directed self-checking bench for tff_toggle_decoder

module tb_tff_toggle_decoder;

  localparam int PEND_W = 4;
  localparam int TOT_W  = 4;

  logic              clk;
  logic              rst;
  logic              tog_in;
  logic              evt_pulse;
  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;
  logic              ovf_clr;
`ifdef TFF_DEC_STAT_EN
  logic [TOT_W-1:0]  evt_total;
`endif

  int n_vec;
  int n_err;

  tff_toggle_decoder #(
    .SYNC_STAGES(2),
    .PEND_W     (PEND_W),
    .TOT_W      (TOT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
`ifdef TFF_DEC_STAT_EN
    .ovf_clr  (ovf_clr),
    .evt_total(evt_total)
`else
    .ovf_clr  (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One transition, then wait until the event has reached pend_cnt.
  task automatic toggle_event();
    tog_in = ~tog_in;
    ticks(4);
  endtask

  task automatic quiet_window(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {31'd0, evt_pulse}, 32'd0);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    tog_in    = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset with tog_in already high: no event may appear after release.
    ticks(3);
    check("rst_pend", {28'd0, pend_cnt}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_pulse", {31'd0, evt_pulse}, 32'd0);
    rst = 1'b0;
    quiet_window("init_no_pulse", 10);
    check("init_pend", {28'd0, pend_cnt}, 32'd0);
    check("init_valid", {31'd0, evt_valid}, 32'd0);

    // Latency: change before E0, pulse only in the cycle after E2.
    tog_in = 1'b0;
    tick();
    check("lat_e0", {31'd0, evt_pulse}, 32'd0);
    tick();
    check("lat_e1", {31'd0, evt_pulse}, 32'd0);
    tick();
    check("lat_e2", {31'd0, evt_pulse}, 32'd1);
    tick();
    check("lat_e3_pulse", {31'd0, evt_pulse}, 32'd0);
    check("lat_e3_pend", {28'd0, pend_cnt}, 32'd1);
    check("lat_e3_valid", {31'd0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("single_pend", {28'd0, pend_cnt}, 32'd0);
    check("single_valid", {31'd0, evt_valid}, 32'd0);

    // evt_ready while nothing is pending is ignored.
    evt_ready = 1'b1;
    ticks(2);
    evt_ready = 1'b0;
    check("idle_ready_pend", {28'd0, pend_cnt}, 32'd0);

    // Accumulate five events, then drain them one per cycle.
    for (int i = 0; i < 5; i++) toggle_event();
    check("acc_pend", {28'd0, pend_cnt}, 32'd5);
    check("acc_valid", {31'd0, evt_valid}, 32'd1);
    evt_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("drain_pend", {28'd0, pend_cnt}, i);
    end
    evt_ready = 1'b0;
    check("drain_valid", {31'd0, evt_valid}, 32'd0);

    // Fill to PMAX; the sixteenth event is dropped and sets ovf.
    for (int i = 0; i < 15; i++) toggle_event();
    check("full15_pend", {28'd0, pend_cnt}, 32'd15);
    check("full15_ovf", {31'd0, ovf}, 32'd0);
    toggle_event();
    check("full16_pend", {28'd0, pend_cnt}, 32'd15);
    check("full16_ovf", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);

    // In FULL, an event coincident with a handshake keeps 15 with no overflow.
    tog_in = ~tog_in;
    ticks(3);
    check("full_coinc_pulse", {31'd0, evt_pulse}, 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_coinc_pend", {28'd0, pend_cnt}, 32'd15);
    check("full_coinc_ovf", {31'd0, ovf}, 32'd0);

    // Overflow and ovf_clr in the same cycle: set wins.
    ovf_clr = 1'b1;
    toggle_event();
    ovf_clr = 1'b0;
    check("ovf_set_wins", {31'd0, ovf}, 32'd1);

    // Leave FULL by a single handshake.
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_to_pend", {28'd0, pend_cnt}, 32'd14);

    // Drain completely.
    evt_ready = 1'b1;
    ticks(14);
    evt_ready = 1'b0;
    check("drain_all_pend", {28'd0, pend_cnt}, 32'd0);
    check("drain_all_valid", {31'd0, evt_valid}, 32'd0);
    check("drain_all_ovf", {31'd0, ovf}, 32'd1);

    // Simultaneous inc and dec in PEND: count unchanged.
    for (int i = 0; i < 3; i++) toggle_event();
    check("sim_pre_pend", {28'd0, pend_cnt}, 32'd3);
    tog_in = ~tog_in;
    ticks(3);
    check("sim_pulse", {31'd0, evt_pulse}, 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("sim_pend", {28'd0, pend_cnt}, 32'd3);

    // Asynchronous reset mid-cycle clears pending events and ovf at once.
    #2;
    rst = 1'b1;
    #1;
    check("arst_pend", {28'd0, pend_cnt}, 32'd0);
    check("arst_valid", {31'd0, evt_valid}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst = 1'b0;
    quiet_window("rearm_no_pulse", 10);
    check("rearm_pend", {28'd0, pend_cnt}, 32'd0);

`ifdef TFF_DEC_STAT_EN
    // Statistic: 17 events into a 4-bit total wraps to 1; ovf_clr leaves it.
    rst = 1'b1;
    tick();
    check("stat_rst", {28'd0, evt_total}, 32'd0);
    rst = 1'b0;
    ticks(5);
    for (int i = 0; i < 17; i++) toggle_event();
    check("stat_wrap", {28'd0, evt_total}, 32'd1);
    check("stat_pend", {28'd0, pend_cnt}, 32'd15);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("stat_ovf_clr", {28'd0, evt_total}, 32'd1);
    check("stat_ovf", {31'd0, ovf}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
